rv32i_instr_encoder_loader: RTL and testbench

Encodes RV32I instruction fields into 32-bit machine words and streams them into instruction memory. It performs the reverse of the opcode decode done by the main control unit. The block is the core's boot/test loader. It sits beside the instruction-memory write port and is driven by a testbench, debug port or host bridge through a valid/ready field interface. Each run writes a counted block of words starting at a base word address, then pulses `done`.

---
 rtl/rv32i_pkg.sv | 41 ++++
 rtl/rv32i_instr_encoder_loader_if.sv | 24 ++
 rtl/rv32i_instr_packer.sv | 73 +++++++
 rtl/rv32i_instr_encoder_loader.sv | 127 ++++++++++++
 tb/tb_rv32i_instr_encoder_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: base opcodes, the canonical NOP and the instruction-format
// classification used by the encoder.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_ILLEGAL
  } fmt_e;

  function automatic fmt_e opc_format(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_OP:                       f = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: f = FMT_I;
      OPC_STORE:                    f = FMT_S;
      OPC_BRANCH:                   f = FMT_B;
      OPC_LUI, OPC_AUIPC:           f = FMT_U;
      OPC_JAL:                      f = FMT_J;
      default:                      f = FMT_ILLEGAL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/rv32i_instr_encoder_loader_if.sv
// Valid/ready stream of RV32I instruction fields from a host into the encoder.
interface rv32i_instr_encoder_loader_if;

  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
    output in_ready
  );

endinterface

// File: rtl/rv32i_instr_packer.sv
// Combinational RV32I field packer: builds the machine word from decoded fields and
// substitutes NOP when the opcode is unsupported or the immediate cannot be encoded.
module rv32i_instr_packer
  import rv32i_pkg::*;
(
  input  logic [6:0]  opcode_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o,
  output logic        range_err_o
);

  fmt_e        fmt;
  logic        is_shift;
  logic [2:0]  f3;
  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic [31:0] raw;
  logic        ill;
  logic        rng;

  always_comb begin
    fmt      = opc_format(opcode_i);
    is_shift = (opcode_i == OPC_OP_IMM) && (funct3_i[1:0] == 2'b01);
    f3       = (opcode_i == OPC_JALR) ? 3'b000 : funct3_i;
    // Signed fit: every bit above the field's sign bit equals that sign bit.
    fits12   = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
    fits13   = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);
    fits21   = (imm_i[31:20] == '0) || (imm_i[31:20] == '1);
    raw      = '0;
    rng      = 1'b0;
    ill      = 1'b0;
    case (fmt)
      FMT_R: raw = {funct7_i, rs2_i, rs1_i, f3, rd_i, opcode_i};
      FMT_I: begin
        if (is_shift) begin
          raw = {funct7_i, imm_i[4:0], rs1_i, f3, rd_i, opcode_i};
          rng = (imm_i[31:5] != '0);
        end else begin
          raw = {imm_i[11:0], rs1_i, f3, rd_i, opcode_i};
          rng = !fits12;
        end
      end
      FMT_S: begin
        raw = {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], opcode_i};
        rng = !fits12;
      end
      FMT_B: begin
        raw = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3, imm_i[4:1], imm_i[11], opcode_i};
        rng = !fits13 || imm_i[0];
      end
      FMT_U: begin
        raw = {imm_i[31:12], rd_i, opcode_i};
        rng = (imm_i[11:0] != '0);
      end
      FMT_J: begin
        raw = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
        rng = !fits21 || imm_i[0];
      end
      default: ill = 1'b1;
    endcase
    illegal_o   = ill;
    range_err_o = rng;
    word_o      = (ill || rng) ? NOP : raw;
  end

endmodule

// File: rtl/rv32i_instr_encoder_loader.sv
// Boot/test loader: accepts RV32I instruction fields, encodes them and writes a counted
// block of words into instruction memory from a base address, then pulses done.
module rv32i_instr_encoder_loader
  import rv32i_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [CNT_W-1:0]     count,
  rv32i_instr_encoder_loader_if.slave fld,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err_illegal,
  output logic                 err_range
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FINISH
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    rem_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [31:0]         wdata_q;
  logic                ill_q;
  logic                rng_q;

  logic                ready;
  logic                xfer;
  logic                launch;
  logic [31:0]         word;
  logic                word_ill;
  logic                word_rng;

  rv32i_instr_packer u_packer (
    .opcode_i    (fld.in_opcode),
    .rd_i        (fld.in_rd),
    .rs1_i       (fld.in_rs1),
    .rs2_i       (fld.in_rs2),
    .funct3_i    (fld.in_funct3),
    .funct7_i    (fld.in_funct7),
    .imm_i       (fld.in_imm),
    .word_o      (word),
    .illegal_o   (word_ill),
    .range_err_o (word_rng)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    xfer    = 1'b0;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          launch  = (count != '0);
          state_d = (count == '0) ? FINISH : LOAD;
        end
      end
      LOAD: begin
        ready = 1'b1;
        busy  = 1'b1;
        xfer  = fld.in_valid;
        if (xfer && rem_q == CNT_W'(1)) state_d = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ill_q   <= 1'b0;
      rng_q   <= 1'b0;
    end else begin
      we_q <= xfer;
      if (launch) begin
        rem_q  <= count;
        addr_q <= base_addr;
        ill_q  <= 1'b0;
        rng_q  <= 1'b0;
      end
      if (xfer) begin
        rem_q   <= rem_q - CNT_W'(1);
        addr_q  <= addr_q + ADDR_W'(1);
        waddr_q <= addr_q;
        wdata_q <= word;
        ill_q   <= ill_q | word_ill;
        rng_q   <= rng_q | word_rng;
      end
    end
  end

  assign fld.in_ready = ready;
  assign imem_we      = we_q;
  assign imem_addr    = waddr_q;
  assign imem_wdata   = wdata_q;
  assign err_illegal  = ill_q;
  assign err_range    = rng_q;

endmodule

// File: tb/tb_rv32i_instr_encoder_loader.sv
// Bench for the RV32I encoder/loader: directed scenarios with literal expectations plus
// randomized runs checked every cycle against a transaction-level reference model.
module tb_rv32i_instr_encoder_loader;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  count = '0;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              busy;
  logic              done;
  logic              err_illegal;
  logic              err_range;

  rv32i_instr_encoder_loader_if bus ();

  rv32i_instr_encoder_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .count       (count),
    .fld         (bus),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .busy        (busy),
    .done        (done),
    .err_illegal (err_illegal),
    .err_range   (err_range)
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference encoder: fields placed by shift-and-mask arithmetic on integer values.
  function automatic void m_encode(input int op, input int rd, input int rs1, input int rs2,
                                   input int f3, input int f7, input int imm,
                                   output bit [31:0] w, output bit ill, output bit rng);
    int g3;
    ill = 0;
    rng = 0;
    w   = 0;
    g3  = (op == 'h67) ? 0 : f3;
    case (op)
      'h33: w = 32'((f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op);
      'h13, 'h03, 'h67: begin
        if (op == 'h13 && (f3 == 1 || f3 == 5)) begin
          rng = !(imm >= 0 && imm <= 31);
          w = 32'((f7 << 25) | ((imm & 'h1F) << 20) | (rs1 << 15) | (g3 << 12) | (rd << 7) | op);
        end else begin
          rng = !(imm >= -2048 && imm <= 2047);
          w = 32'(((imm & 'hFFF) << 20) | (rs1 << 15) | (g3 << 12) | (rd << 7) | op);
        end
      end
      'h23: begin
        rng = !(imm >= -2048 && imm <= 2047);
        w = 32'((((imm >> 5) & 'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                | ((imm & 'h1F) << 7) | op);
      end
      'h63: begin
        rng = !(imm >= -4096 && imm <= 4095 && (imm % 2) == 0);
        w = 32'((((imm >> 12) & 1) << 31) | (((imm >> 5) & 'h3F) << 25) | (rs2 << 20)
                | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 'hF) << 8)
                | (((imm >> 11) & 1) << 7) | op);
      end
      'h37, 'h17: begin
        rng = (imm & 'hFFF) != 0;
        w = 32'(imm) & 32'hFFFF_F000 | 32'((rd << 7) | op);
      end
      'h6F: begin
        rng = !(imm >= -1048576 && imm <= 1048575 && (imm % 2) == 0);
        w = 32'((((imm >> 20) & 1) << 31) | (((imm >> 1) & 'h3FF) << 21)
                | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 'hFF) << 12) | (rd << 7) | op);
      end
      default: ill = 1;
    endcase
    if (ill || rng) w = 32'h0000_0013;
  endfunction

  // Run-level model: remaining words, next address and expected outputs for the next cycle.
  bit        live = 0;
  bit        m_run = 0;
  int        m_left = 0;
  int        m_addr = 0;
  bit        e_we = 0, e_done = 0, e_busy = 0, e_ill = 0, e_rng = 0;
  int        e_addr = 0;
  bit [31:0] e_data = 0;

  always @(posedge clk) begin
    bit        idle;
    bit [31:0] w;
    bit        il, rg;
    if (rst) begin
      live = 1; m_run = 0; m_left = 0; m_addr = 0;
      e_we = 0; e_done = 0; e_busy = 0; e_ill = 0; e_rng = 0; e_addr = 0; e_data = 0;
    end else begin
      idle   = !m_run && !e_done;
      e_we   = 0;
      e_done = 0;
      if (m_run && bus.in_valid) begin
        m_encode(int'(bus.in_opcode), int'(bus.in_rd), int'(bus.in_rs1), int'(bus.in_rs2),
                 int'(bus.in_funct3), int'(bus.in_funct7), int'(bus.in_imm), w, il, rg);
        e_we   = 1;
        e_addr = m_addr;
        e_data = w;
        e_ill  = e_ill | il;
        e_rng  = e_rng | rg;
        m_addr = (m_addr + 1) % (1 << ADDR_W);
        m_left--;
        if (m_left == 0) begin m_run = 0; e_done = 1; end
      end else if (idle && start) begin
        if (count == 0) e_done = 1;
        else begin
          m_run = 1; m_left = int'(count); m_addr = int'(base_addr); e_ill = 0; e_rng = 0;
        end
      end
      e_busy = m_run;
    end
  end

  int        wlog_a[$];
  bit [31:0] wlog_d[$];

  always @(negedge clk) begin
    if (live) begin
      check("in_ready", 32'(bus.in_ready), 32'(e_busy));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("imem_we", 32'(imem_we), 32'(e_we));
      check("err_illegal", 32'(err_illegal), 32'(e_ill));
      check("err_range", 32'(err_range), 32'(e_rng));
      if (e_we) begin
        check("imem_addr", 32'(imem_addr), 32'(e_addr));
        check("imem_wdata", imem_wdata, e_data);
      end
      if (imem_we === 1'b1) begin
        wlog_a.push_back(int'(imem_addr));
        wlog_d.push_back(imem_wdata);
      end
    end
  end

  task automatic set_fields(input int op, input int rd, input int rs1, input int rs2,
                            input int f3, input int f7, input int imm);
    bus.in_opcode = 7'(op);
    bus.in_rd     = 5'(rd);
    bus.in_rs1    = 5'(rs1);
    bus.in_rs2    = 5'(rs2);
    bus.in_funct3 = 3'(f3);
    bus.in_funct7 = 7'(f7);
    bus.in_imm    = 32'(imm);
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2,
                      input int f3, input int f7, input int imm);
    set_fields(op, rd, rs1, rs2, f3, f7, imm);
    bus.in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic begin_run(input int b, input int n);
    start     = 1'b1;
    base_addr = ADDR_W'(b);
    count     = CNT_W'(n);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wlog_a.delete();
    wlog_d.delete();
  endtask

  task automatic check_log(input string name, input int idx, input int a, input bit [31:0] d);
    if (idx < wlog_a.size()) begin
      check({name, "_addr"}, 32'(wlog_a[idx]), 32'(a));
      check({name, "_data"}, wlog_d[idx], d);
    end else begin
      check({name, "_present"}, 32'(wlog_a.size()), 32'(idx + 1));
    end
  endtask

  int op_pool[9]   = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h37, 'h17, 'h6F, 'h67};
  int imm_pool[16] = '{2047, -2048, 2048, -2049, 31, 32, -1, 4094, -4096, 4096,
                       -4098, 1, 1048574, -1048576, 1048576, 'h12345000};

  task automatic rand_fields();
    int op, imm, sel;
    op  = ($urandom % 10 == 0) ? int'($urandom % 128) : op_pool[$urandom % 9];
    sel = int'($urandom % 4);
    case (sel)
      0:       imm = imm_pool[$urandom % 16];
      1:       imm = int'($urandom_range(0, 4095)) - 2048;
      2:       imm = int'($urandom & 32'hFFFF_F000);
      default: imm = (int'($urandom_range(0, 8191)) - 4096) & ~1;
    endcase
    set_fields(op, int'($urandom % 32), int'($urandom % 32), int'($urandom % 32),
               int'($urandom % 8), int'($urandom % 128), imm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int n;
    bus.in_valid = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_imem_addr", 32'(imem_addr), 32'h0);
    check("rst_imem_wdata", imem_wdata, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // addi x1,x0,5 : single-word run
    clear_log();
    begin_run('h010, 1);
    send('h13, 1, 0, 0, 0, 0, 5);
    bus.in_valid = 1'b0;
    check("t1_we", 32'(imem_we), 32'h1);
    check("t1_addr", 32'(imem_addr), 32'h010);
    check("t1_data", imem_wdata, 32'h0050_0093);
    check("t1_done", 32'(done), 32'h1);
    idle_cycles(2);

    // add / beq -4 / lui with in_valid held high
    clear_log();
    begin_run('h020, 3);
    send('h33, 3, 1, 2, 0, 0, 0);
    send('h63, 0, 1, 2, 0, 0, -4);
    send('h37, 5, 0, 0, 0, 0, 'h12345000);
    idle_cycles(2);
    check_log("t2_w0", 0, 'h020, 32'h0020_81B3);
    check_log("t2_w1", 1, 'h021, 32'hFE20_8EE3);
    check_log("t2_w2", 2, 'h022, 32'h1234_52B7);

    // jal, illegal opcode, out-of-range addi; then flags clear on next start
    clear_log();
    begin_run('h040, 3);
    send('h6F, 1, 0, 0, 0, 0, 2048);
    send('h7F, 1, 2, 3, 0, 0, 0);
    send('h13, 1, 0, 0, 0, 0, 2048);
    idle_cycles(2);
    check_log("t3_jal", 0, 'h040, 32'h0010_00EF);
    check_log("t3_ill", 1, 'h041, 32'h0000_0013);
    check_log("t3_rng", 2, 'h042, 32'h0000_0013);
    check("t3_err_illegal", 32'(err_illegal), 32'h1);
    check("t3_err_range", 32'(err_range), 32'h1);
    begin_run('h050, 1);
    check("t3_illegal_cleared", 32'(err_illegal), 32'h0);
    check("t3_range_cleared", 32'(err_range), 32'h0);
    send('h13, 2, 0, 0, 0, 0, -1);
    idle_cycles(2);

    // address wrap at the top of a 10-bit space
    clear_log();
    begin_run('h3FF, 2);
    send('h13, 1, 0, 0, 0, 0, 1);
    send('h13, 2, 0, 0, 0, 0, 2);
    idle_cycles(2);
    check_log("t4_w0", 0, 'h3FF, 32'h0010_0093);
    check_log("t4_w1", 1, 'h000, 32'h0020_0113);

    // zero-length run
    clear_log();
    begin_run('h100, 0);
    check("t5_done", 32'(done), 32'h1);
    check("t5_busy", 32'(busy), 32'h0);
    @(negedge clk);
    check("t5_done_low", 32'(done), 32'h0);
    idle_cycles(2);
    check("t5_no_writes", 32'(wlog_a.size()), 32'h0);

    // toggled in_valid with a stray start mid-run
    clear_log();
    begin_run('h080, 2);
    send('h13, 1, 0, 0, 0, 0, 7);
    bus.in_valid = 1'b0;
    start = 1'b1; base_addr = ADDR_W'('h1F0); count = CNT_W'(5);
    @(negedge clk);
    send('h13, 2, 0, 0, 0, 0, 8);
    start = 1'b0;
    idle_cycles(3);
    check("t6_nwrites", 32'(wlog_a.size()), 32'h2);
    check_log("t6_w0", 0, 'h080, 32'h0070_0093);
    check_log("t6_w1", 1, 'h081, 32'h0080_0113);

    // reset after two of four transfers discards the pending write
    begin_run('h100, 4);
    send('h13, 1, 0, 0, 0, 0, 1);
    send('h13, 2, 0, 0, 0, 0, 2);
    rst = 1'b1;
    send('h13, 3, 0, 0, 0, 0, 3);
    check("t7_we", 32'(imem_we), 32'h0);
    check("t7_addr", 32'(imem_addr), 32'h0);
    check("t7_data", imem_wdata, 32'h0);
    check("t7_ready", 32'(bus.in_ready), 32'h0);
    check("t7_busy", 32'(busy), 32'h0);
    check("t7_done", 32'(done), 32'h0);
    rst = 1'b0;
    idle_cycles(1);
    clear_log();
    begin_run('h200, 2);
    send('h13, 4, 0, 0, 0, 0, 4);
    send('h13, 5, 0, 0, 0, 0, 5);
    idle_cycles(2);
    check_log("t7_w0", 0, 'h200, 32'h0040_0213);
    check_log("t7_w1", 1, 'h201, 32'h0050_0293);

    // randomized runs
    for (int r = 0; r < 40; r++) begin
      n = int'($urandom_range(1, 8));
      rand_fields();
      bus.in_valid = 1'($urandom % 2);
      begin_run(int'($urandom % 1024), n);
      cyc = 0;
      while (busy === 1'b1 && cyc < 200) begin
        rand_fields();
        bus.in_valid = (($urandom % 10) < 7);
        start        = ($urandom % 6 == 0);
        base_addr    = ADDR_W'($urandom);
        count        = CNT_W'($urandom);
        @(negedge clk);
        cyc++;
      end
      start = 1'b0;
      bus.in_valid = 1'($urandom % 2);
      check("rand_run_ends", 32'(cyc < 200), 32'h1);
      @(negedge clk);
    end
    idle_cycles(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
